// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU as
// multi-cycle operations and drives the pipeline hold vector.
module mdu_e #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] rd_data,
  output logic [2:0]  busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        is_md_s, is_any_s, start_s;
  logic [63:0] md_res_s;

  // Product of operands extended to 64 bits; the low 64 bits are exact for both signednesses.
  function automatic logic [63:0] mul_result(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
    logic [63:0] ex;
    logic [63:0] ey;
    ex = sgn ? {{32{x[31]}}, x} : {32'd0, x};
    ey = sgn ? {{32{y[31]}}, y} : {32'd0, y};
    return ex * ey;
  endfunction

  // Divide on magnitudes, then restore signs; 0x8000_0000 / -1 falls out as 0x8000_0000 rem 0.
  function automatic logic [63:0] div_result(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
    logic        nx, ny;
    logic [31:0] ax, ay, q, r;
    logic [63:0] res;
    nx = sgn & x[31];
    ny = sgn & y[31];
    ax = nx ? (32'd0 - x) : x;
    ay = ny ? (32'd0 - y) : y;
    if (y == 32'd0) begin
      res = {x, 32'hFFFF_FFFF};
    end else begin
      q   = ax / ay;
      r   = ax % ay;
      q   = (nx ^ ny) ? (32'd0 - q) : q;
      r   = nx ? (32'd0 - r) : r;
      res = {r, q};
    end
    return res;
  endfunction

  always_comb begin
    is_md_s  = op_valid && (op >= OP_MULT) && (op <= OP_DIVU);
    is_any_s = op_valid && (op >= OP_MULT) && (op <= OP_MFLO);
    start_s  = is_md_s && (state_q == ST_IDLE);
    busy     = {is_any_s && (state_q == ST_RUN), state_q == ST_RUN, start_s};
    case (op)
      OP_MULT:  md_res_s = mul_result(a, b, 1'b1);
      OP_MULTU: md_res_s = mul_result(a, b, 1'b0);
      OP_DIV:   md_res_s = div_result(a, b, 1'b1);
      OP_DIVU:  md_res_s = div_result(a, b, 1'b0);
      default:  md_res_s = 64'd0;
    endcase
    if (op_valid && (op == OP_MFHI)) begin
      rd_data = hi_q;
    end else if (op_valid && (op == OP_MFLO)) begin
      rd_data = lo_q;
    end else begin
      rd_data = 32'd0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          pend_hi_d = md_res_s[63:32];
          pend_lo_d = md_res_s[31:0];
          cnt_d     = (op <= OP_MULTU) ? MUL_CNT : DIV_CNT;
          state_d   = ST_RUN;
        end else if (op_valid && (op == OP_MTHI)) begin
          hi_d = a;
        end else if (op_valid && (op == OP_MTLO)) begin
          lo_d = a;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == 4'd0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and architectural registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
